md5_stream_core: RTL
====================

Name: md5_stream_core

Overview:
- Parametrised MD5 compression engine for the password-authenticator datapath. Supersedes the fixed 128-bit-load, single-block core.
- Accepts pre-padded 512-bit message blocks over a ready/valid word stream of configurable width.
- Chains the hash state across any number of blocks and computes 1, 2 or 4 MD5 steps per clock.
- Presents the final 128-bit digest on a ready/valid output held until consumed. Sits between the password framer/padder and the digest comparator.

Parameters:
- IN_W, 32, input beat width. Legal values: 32, 64, 128, 512. Beats per block = 512/IN_W.
- STEPS_PER_CYCLE, 1, MD5 steps per clock. Legal values: 1, 2, 4. Compression cycles = 64/STEPS_PER_CYCLE.
- SWAP_BYTES, 1, byte order.
  - 1: input words are in stream (big-endian byte) order and are byte-reversed into M[i]. Digest is emitted in canonical hex-string order.
  - 0: words are used raw as M[i] and {A,B,C,D} are emitted raw.

Ports:
- clk  in  1  clock. Single clock domain.
- reset  in  1  asynchronous, active-low reset.
- init_i  in  1  synchronous restart: reload IV, drop any partial block, abort compression.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  core can accept a beat.
- in_data_i  in  IN_W  beat data. First 32 bits of the block are at the MSB of the first beat; that word is M[0].
- in_last_i  in  1  the current block is the final block of the message. Sampled only on a block's final beat.
- digest_valid_o  out  1  digest available.
- digest_ready_i  in  1  consumer accepts the digest.
- digest_o  out  128  {A,B,C,D} after the add-back, ordered per SWAP_BYTES.
- busy_o  out  1  high in RUN, ADD and OUT states.
- blocks_o  out  16  count of blocks compressed since the last init/reset. Saturates at 0xFFFF.

Behaviour:
- Reset (reset low, asynchronous):
  - state LOAD, beat counter 0.
  - A..D and the working registers set to IV: 67452301, EFCDAB89, 98BADCFE, 10325476.
  - in_ready_o=0 during reset, then 1 on the first clock after release.
  - digest_valid_o=0, digest_o=0, busy_o=0, blocks_o=0.
- States: LOAD -> RUN -> ADD -> (LOAD | OUT) -> LOAD.
- LOAD:
  - in_ready_o=1. A beat transfers when in_valid_i and in_ready_o are both high.
  - Beat k writes message bits [511-k*IN_W -: IN_W].
  - On the final beat: latch in_last_i, copy A..D into the working registers, go to RUN.
- RUN:
  - Performs STEPS_PER_CYCLE chained steps per clock using F/G/H/I, K[i], s[i], g(i) from standard MD5.
  - Step counter wraps 63 -> 0. All arithmetic is mod 2^32. Rotation is a true rotate (s is never 0 or 32).
  - Exits to ADD after 64/STEPS_PER_CYCLE cycles.
- ADD (1 cycle):
  - A+=a, B+=b, C+=c, D+=d. blocks_o increments.
  - If the latched last flag is 0: go to LOAD; in_ready_o is high the next cycle.
  - If the latched last flag is 1: register digest_o, set digest_valid_o, reload A..D with IV, go to OUT.
- OUT:
  - in_ready_o=0. digest_o and digest_valid_o are held stable until digest_ready_i is high.
  - The handshake cycle returns to LOAD. digest_valid_o is low the next cycle. digest_o retains its value.
- Latency: from the clock accepting a block's final beat to digest_valid_o high = 64/STEPS_PER_CYCLE + 1 cycles. The same figure applies to in_ready_o reasserting for a non-last block.
- Throughput, back-to-back non-last blocks: 512/IN_W + 64/STEPS_PER_CYCLE + 1 cycles per block.
- in_valid_i while in_ready_o=0: ignored, no data lost from the core's side. The producer must hold the beat.
- init_i has priority over everything and can occur in any state:
  - next state LOAD, beat counter 0, A..D = IV, digest_valid_o=0, blocks_o=0.
  - A beat presented in the same cycle is discarded.
  - An undelivered digest in OUT is dropped.
- Reset asserted mid-RUN or mid-OUT: immediate return to reset values. No partial digest is ever flagged valid.
- in_last_i on non-final beats: don't-care.

Decomposition:
- Shared package md5_pkg:
  - K[0..63] constants, s[0..63] shift amounts, message index g(i).
  - IV words, state encoding (LOAD/RUN/ADD/OUT).
  - Byte-swap function.
- Sub-module md5_step: purely combinational single MD5 step.
  - Inputs: a, b, c, d, step index, M[g].
  - Outputs: next a..d.
  - Instantiated STEPS_PER_CYCLE times in a chain inside md5_stream_core.

Test Plan:
- Empty message, SWAP_BYTES=1, IN_W=32: 16 beats, first 80000000, rest 0, in_last_i=1 -> digest_o=d41d8cd98f00b204e9800998ecf8427e, valid exactly 65 cycles after the last beat.
- "abc", SWAP_BYTES=1, IN_W=128, STEPS_PER_CYCLE=4:
  - block words 61626380, 0 x13, word14=18000000, word15=0.
  - expect digest_o=900150983cd24fb0d6963f7d28e17f72 after 17 cycles.
- Two-block message, "a" repeated 64 times plus a padding block:
  - expect digest_o=014842d480b571495a4a0363793f7367, blocks_o=2.
  - in_ready_o low for exactly 65 cycles between blocks.
- Backpressure: hold digest_ready_i=0 for 20 cycles -> digest_o/digest_valid_o stable, in_ready_o=0, in_valid_i beats ignored. Release -> LOAD, then a new "" hash gives d41d8cd9...
- init_i pulsed mid-RUN of the "abc" block, then the "" block sent -> no digest for "abc"; output d41d8cd98f00b204e9800998ecf8427e, blocks_o=1.
- Async reset asserted at RUN cycle 30 -> all outputs at reset values immediately. Re-hash "abc" -> correct digest, blocks_o=1.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and helper functions.
package md5_pkg;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts repeat every 4 steps within a round: index {round, step%4}.
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] md5_k(input logic [5:0] i);
    return K_TAB[i];
  endfunction

  function automatic logic [4:0] md5_s(input logic [5:0] i);
    return S_TAB[{i[5:4], i[1:0]}];
  endfunction

  // Message word index; the round offset is a multiple of 16 so 4-bit math suffices.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] j;
    j = i[3:0];
    case (i[5:4])
      2'd0:    return j;
      2'd1:    return j * 4'd5 + 4'd1;
      2'd2:    return j * 4'd3 + 4'd5;
      default: return j * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: rotates the a..d window and folds in M[g].
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [5:0]  idx_i,
  input  logic [31:0] m_i,
  output logic [31:0] a_c,
  output logic [31:0] b_c,
  output logic [31:0] c_c,
  output logic [31:0] d_c
);

  logic [31:0] f;
  logic [31:0] t;
  logic [4:0]  s_amt;

  // Round function, sum and rotate-add.
  always_comb begin
    case (idx_i[5:4])
      2'd0:    f = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f = (b_i & d_i) | (c_i & ~d_i);
      2'd2:    f = b_i ^ c_i ^ d_i;
      default: f = c_i ^ (b_i | ~d_i);
    endcase
    s_amt = md5_s(idx_i);
    t     = a_i + f + md5_k(idx_i) + m_i;
    a_c   = d_i;
    b_c   = b_i + ((t << s_amt) | (t >> (6'd32 - 6'(s_amt))));
    c_c   = b_i;
    d_c   = c_i;
  end

endmodule

// File: rtl/md5_stream_core.sv
// Streaming multi-block MD5 engine with chained state and held digest output.
module md5_stream_core
  import md5_pkg::*;
#(
  parameter int unsigned IN_W            = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1,
  parameter bit          SWAP_BYTES      = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [IN_W-1:0] in_data_i,
  input  logic            in_last_i,
  output logic            digest_valid_o,
  input  logic            digest_ready_i,
  output logic [127:0]    digest_o,
  output logic            busy_o,
  output logic [15:0]     blocks_o
);

  localparam int unsigned BEATS     = 512 / IN_W;
  localparam int unsigned BEAT_CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SPC       = STEPS_PER_CYCLE;
  localparam logic [5:0]  LAST_STEP = 6'(64 - SPC);

  logic [1:0]         state_q, state_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic [511:0]       msg_q, msg_d;
  logic               last_q, last_d;
  logic [31:0]        ha_q, hb_q, hc_q, hd_q, ha_d, hb_d, hc_d, hd_d;
  logic [31:0]        wa_q, wb_q, wc_q, wd_q, wa_d, wb_d, wc_d, wd_d;
  logic [5:0]         step_q, step_d;
  logic [127:0]       digest_q, digest_d;
  logic               dvalid_q, dvalid_d;
  logic [15:0]        blocks_q, blocks_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic [31:0] m_w [16];
  logic [31:0] ca [SPC+1];
  logic [31:0] cb [SPC+1];
  logic [31:0] cc [SPC+1];
  logic [31:0] cd [SPC+1];
  logic [5:0]  sidx [SPC];
  logic [31:0] sum_a, sum_b, sum_c, sum_d;

  // Message words M[0..15], optionally byte-reversed from stream order.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      if (SWAP_BYTES) m_w[i] = bswap32(msg_q[511 - 32*i -: 32]);
      else            m_w[i] = msg_q[511 - 32*i -: 32];
    end
  end

  assign ca[0] = wa_q;
  assign cb[0] = wb_q;
  assign cc[0] = wc_q;
  assign cd[0] = wd_q;

  for (genvar j = 0; j < SPC; j++) begin : g_step
    assign sidx[j] = step_q + 6'(j);
    md5_step u_step (
      .a_i   (ca[j]),
      .b_i   (cb[j]),
      .c_i   (cc[j]),
      .d_i   (cd[j]),
      .idx_i (sidx[j]),
      .m_i   (m_w[md5_g(sidx[j])]),
      .a_c   (ca[j+1]),
      .b_c   (cb[j+1]),
      .c_c   (cc[j+1]),
      .d_c   (cd[j+1])
    );
  end

  assign sum_a = ha_q + wa_q;
  assign sum_b = hb_q + wb_q;
  assign sum_c = hc_q + wc_q;
  assign sum_d = hd_q + wd_q;

  // Next-state and datapath control; init_i overrides every state.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    msg_d    = msg_q;
    last_d   = last_q;
    ha_d = ha_q; hb_d = hb_q; hc_d = hc_q; hd_d = hd_q;
    wa_d = wa_q; wb_d = wb_q; wc_d = wc_q; wd_d = wd_q;
    step_d   = step_q;
    digest_d = digest_q;
    dvalid_d = dvalid_q;
    blocks_d = blocks_q;
    if (init_i) begin
      state_d  = ST_LOAD;
      beat_d   = '0;
      step_d   = '0;
      ha_d = IV_A; hb_d = IV_B; hc_d = IV_C; hd_d = IV_D;
      wa_d = IV_A; wb_d = IV_B; wc_d = IV_C; wd_d = IV_D;
      dvalid_d = 1'b0;
      blocks_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
              if (beat_q == BEAT_CW'(k)) msg_d[511 - k*IN_W -: IN_W] = in_data_i;
            end
            if (beat_q == BEAT_CW'(BEATS - 1)) begin
              beat_d  = '0;
              last_d  = in_last_i;
              wa_d = ha_q; wb_d = hb_q; wc_d = hc_q; wd_d = hd_q;
              step_d  = '0;
              state_d = ST_RUN;
            end else begin
              beat_d = beat_q + BEAT_CW'(1);
            end
          end
        end
        ST_RUN: begin
          wa_d = ca[SPC]; wb_d = cb[SPC]; wc_d = cc[SPC]; wd_d = cd[SPC];
          step_d = step_q + 6'(SPC);
          if (step_q == LAST_STEP) state_d = ST_ADD;
        end
        ST_ADD: begin
          ha_d = sum_a; hb_d = sum_b; hc_d = sum_c; hd_d = sum_d;
          if (blocks_q != 16'hFFFF) blocks_d = blocks_q + 16'd1;
          if (last_q) begin
            if (SWAP_BYTES) digest_d = {bswap32(sum_a), bswap32(sum_b), bswap32(sum_c), bswap32(sum_d)};
            else            digest_d = {sum_a, sum_b, sum_c, sum_d};
            dvalid_d = 1'b1;
            ha_d = IV_A; hb_d = IV_B; hc_d = IV_C; hd_d = IV_D;
            state_d  = ST_OUT;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_OUT: begin
          if (digest_ready_i) begin
            dvalid_d = 1'b0;
            state_d  = ST_LOAD;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_LOAD);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      beat_q     <= '0;
      msg_q      <= '0;
      last_q     <= 1'b0;
      ha_q <= IV_A; hb_q <= IV_B; hc_q <= IV_C; hd_q <= IV_D;
      wa_q <= IV_A; wb_q <= IV_B; wc_q <= IV_C; wd_q <= IV_D;
      step_q     <= '0;
      digest_q   <= '0;
      dvalid_q   <= 1'b0;
      blocks_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      msg_q      <= msg_d;
      last_q     <= last_d;
      ha_q <= ha_d; hb_q <= hb_d; hc_q <= hc_d; hd_q <= hd_d;
      wa_q <= wa_d; wb_q <= wb_d; wc_q <= wc_d; wd_q <= wd_d;
      step_q     <= step_d;
      digest_q   <= digest_d;
      dvalid_q   <= dvalid_d;
      blocks_q   <= blocks_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign digest_valid_o = dvalid_q;
  assign digest_o       = digest_q;
  assign busy_o         = busy_q;
  assign blocks_o       = blocks_q;

endmodule
